// File: rtl/clock_set_ctrl.sv
// Set-mode controller for a calendar clock: walks the user through the time/date fields,
// issues one-cycle increment strobes (single press and auto-repeat), and blinks the field under edit.
module clock_set_ctrl (
    input  logic       clk_100hz,
    input  logic       rst,
    input  logic       set_press,
    input  logic       inc_press,
    input  logic       inc_hold,
    output logic [2:0] field,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_month,
    output logic       inc_day,
    output logic       inc_year,
    output logic       sec_clr,
    output logic       blink
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'b000,
        ST_HOUR  = 3'b001,
        ST_MIN   = 3'b010,
        ST_MONTH = 3'b011,
        ST_DAY   = 3'b100,
        ST_YEAR  = 3'b101
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  hold_q, hold_d;
    logic [3:0]  rep_q, rep_d;
    logic [9:0]  tmo_q, tmo_d;
    logic [5:0]  blk_cnt_q, blk_cnt_d;
    logic        blink_q, blink_d;
    logic        run_en_q, run_en_d;
    logic [4:0]  strobe_q, strobe_d;   // {year, day, month, min, hour}
    logic        sec_clr_q, sec_clr_d;
    logic        in_set_s, stay_s, timeout_s, auto_s, fire_s;

    // Next-state, strobe, auto-repeat, timeout and blink evaluation
    always_comb begin
        state_d   = state_q;
        in_set_s  = 1'b1;
        timeout_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_set_s = 1'b0;
                if (set_press) state_d = ST_HOUR;
                else           state_d = ST_RUN;
            end
            ST_HOUR:  if (set_press) state_d = ST_MIN;   else state_d = ST_HOUR;
            ST_MIN:   if (set_press) state_d = ST_MONTH; else state_d = ST_MIN;
            ST_MONTH: if (set_press) state_d = ST_DAY;   else state_d = ST_MONTH;
            ST_DAY:   if (set_press) state_d = ST_YEAR;  else state_d = ST_DAY;
            ST_YEAR:  if (set_press) state_d = ST_RUN;   else state_d = ST_YEAR;
            default: begin
                in_set_s = 1'b0;
                state_d  = ST_RUN;
            end
        endcase

        // Idle timeout loses only to an explicit set_press
        if (in_set_s && !set_press && (tmo_q == 10'd999)) begin
            state_d   = ST_RUN;
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end

        stay_s    = in_set_s && (state_d == state_q);
        sec_clr_d = (state_q == ST_MIN) && set_press;
        run_en_d  = (state_d == ST_RUN);

        if (stay_s && inc_hold) begin
            if (hold_q == 7'd127) hold_d = 7'd127;
            else                  hold_d = hold_q + 7'd1;
        end else begin
            hold_d = 7'd0;
        end

        // Repeat sub-counter keeps the 10-cycle cadence going past hold-counter saturation
        auto_s = 1'b0;
        if (hold_d == 7'd50) begin
            auto_s = 1'b1;
            rep_d  = 4'd0;
        end else if ((hold_d != 7'd0) && (hold_q >= 7'd50)) begin
            if (rep_q == 4'd9) begin
                auto_s = 1'b1;
                rep_d  = 4'd0;
            end else begin
                rep_d  = rep_q + 4'd1;
            end
        end else begin
            rep_d = 4'd0;
        end

        fire_s   = stay_s && (inc_press || auto_s);
        strobe_d = 5'b00000;
        if (fire_s) begin
            case (state_q)
                ST_HOUR:  strobe_d = 5'b00001;
                ST_MIN:   strobe_d = 5'b00010;
                ST_MONTH: strobe_d = 5'b00100;
                ST_DAY:   strobe_d = 5'b01000;
                ST_YEAR:  strobe_d = 5'b10000;
                default:  strobe_d = 5'b00000;
            endcase
        end else begin
            strobe_d = 5'b00000;
        end

        if (!stay_s || set_press || inc_press || inc_hold) tmo_d = 10'd0;
        else                                               tmo_d = tmo_q + 10'd1;

        if (!stay_s || fire_s) begin
            blk_cnt_d = 6'd0;
            blink_d   = 1'b0;
        end else if (blk_cnt_q == 6'd49) begin
            blk_cnt_d = 6'd0;
            blink_d   = ~blink_q;
        end else begin
            blk_cnt_d = blk_cnt_q + 6'd1;
            blink_d   = blink_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            hold_q    <= 7'd0;
            rep_q     <= 4'd0;
            tmo_q     <= 10'd0;
            blk_cnt_q <= 6'd0;
            blink_q   <= 1'b0;
            run_en_q  <= 1'b1;
            strobe_q  <= 5'b00000;
            sec_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            tmo_q     <= tmo_d;
            blk_cnt_q <= blk_cnt_d;
            blink_q   <= blink_d;
            run_en_q  <= run_en_d;
            strobe_q  <= strobe_d;
            sec_clr_q <= sec_clr_d;
        end
    end

    assign field     = state_q;
    assign run_en    = run_en_q;
    assign inc_hour  = strobe_q[0];
    assign inc_min   = strobe_q[1];
    assign inc_month = strobe_q[2];
    assign inc_day   = strobe_q[3];
    assign inc_year  = strobe_q[4];
    assign sec_clr   = sec_clr_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: field walk, single/auto-repeat increments, timeout,
// set/inc collision and asynchronous reset during an edit.
module tb_clock_set_ctrl;

    logic       clk_100hz;
    logic       rst;
    logic       set_press, inc_press, inc_hold;
    logic [2:0] field;
    logic       run_en, inc_hour, inc_min, inc_month, inc_day, inc_year, sec_clr, blink;

    int errors = 0;
    int checks = 0;
    int pulses;
    int seen;
    logic [4:0] strobes;

    clock_set_ctrl dut (
        .clk_100hz (clk_100hz),
        .rst       (rst),
        .set_press (set_press),
        .inc_press (inc_press),
        .inc_hold  (inc_hold),
        .field     (field),
        .run_en    (run_en),
        .inc_hour  (inc_hour),
        .inc_min   (inc_min),
        .inc_month (inc_month),
        .inc_day   (inc_day),
        .inc_year  (inc_year),
        .sec_clr   (sec_clr),
        .blink     (blink)
    );

    initial clk_100hz = 1'b0;
    always #5 clk_100hz = ~clk_100hz;

    assign strobes = {inc_year, inc_day, inc_month, inc_min, inc_hour};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100hz);
        #1;
    endtask

    task automatic press_set(input int n);
        for (int i = 0; i < n; i++) begin
            set_press = 1'b1;
            tick();
            set_press = 1'b0;
            tick();
        end
    endtask

    function automatic logic [10:0] outs();
        return {field, run_en, strobes, sec_clr, blink};
    endfunction

    initial begin
        rst = 1'b0; set_press = 1'b0; inc_press = 1'b0; inc_hold = 1'b0;
        tick();
        tick();
        chk("reset_outs", 32'(outs()), 32'(11'b000_1_00000_0_0));
        rst = 1'b1;
        tick();
        chk("run_idle", 32'(outs()), 32'(11'b000_1_00000_0_0));

        // Full field walk, presses 5 cycles apart
        for (int p = 1; p <= 6; p++) begin
            set_press = 1'b1;
            tick();
            set_press = 1'b0;
            chk("walk_field", 32'(field), 32'(p % 6));
            chk("walk_run_en", 32'(run_en), 32'(p == 6));
            chk("walk_sec_clr", 32'(sec_clr), 32'(p == 3));
            chk("walk_blink", 32'(blink), 32'd0);
            for (int j = 0; j < 4; j++) begin
                tick();
                chk("walk_hold_field", 32'(field), 32'(p % 6));
                chk("walk_sec_clr_low", 32'(sec_clr), 32'd0);
            end
        end

        // Single increments in MIN
        press_set(2);
        chk("min_field", 32'(field), 32'd2);
        for (int p = 0; p < 3; p++) begin
            inc_press = 1'b1;
            tick();
            inc_press = 1'b0;
            chk("min_strobe", 32'(strobes), 32'(5'b00010));
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("min_strobe_low", 32'(strobes), 32'd0);
            end
        end

        // Auto-repeat in HOUR
        press_set(5);
        chk("hour_field", 32'(field), 32'd1);
        inc_press = 1'b1;
        inc_hold  = 1'b1;
        pulses    = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            inc_press = 1'b0;
            if (strobes != 5'b00000) pulses++;
            if ((k == 1) || ((k >= 50) && (((k - 50) % 10) == 0)))
                chk("rep_strobe", 32'(strobes), 32'(5'b00001));
            else
                chk("rep_quiet", 32'(strobes), 32'd0);
        end
        inc_hold = 1'b0;
        chk("rep_total", 32'(pulses), 32'd7);
        for (int j = 1; j <= 50; j++) begin
            tick();
            if (j >= 49) chk("blink_toggle", 32'(blink), 32'(j == 50));
        end
        chk("blink_strobes", 32'(strobes), 32'd0);

        // Timeout from DAY
        press_set(2);
        set_press = 1'b1;
        tick();
        set_press = 1'b0;
        chk("day_field", 32'(field), 32'd4);
        seen = 0;
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (sec_clr) seen++;
            if (k == 999) chk("tmo_not_yet", 32'(field), 32'd4);
        end
        chk("tmo_field", 32'(field), 32'd0);
        chk("tmo_run_en", 32'(run_en), 32'd1);
        chk("tmo_sec_clr", 32'(seen), 32'd0);

        // set_press and inc_press together in YEAR
        press_set(5);
        chk("year_field", 32'(field), 32'd5);
        set_press = 1'b1;
        inc_press = 1'b1;
        tick();
        set_press = 1'b0;
        inc_press = 1'b0;
        chk("coll_field", 32'(field), 32'd0);
        chk("coll_strobe", 32'(strobes), 32'd0);
        tick();
        chk("coll_strobe_late", 32'(strobes), 32'd0);

        // Reset during auto-repeat in MONTH
        press_set(3);
        chk("month_field", 32'(field), 32'd3);
        inc_press = 1'b1;
        inc_hold  = 1'b1;
        tick();
        inc_press = 1'b0;
        chk("month_strobe", 32'(strobes), 32'(5'b00100));
        for (int k = 0; k < 52; k++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async", 32'(outs()), 32'(11'b000_1_00000_0_0));
        tick();
        chk("rst_held", 32'(outs()), 32'(11'b000_1_00000_0_0));
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if ((strobes != 5'b00000) || (field != 3'd0)) seen++;
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);
        inc_hold = 1'b0;
        set_press = 1'b1;
        tick();
        set_press = 1'b0;
        chk("post_rst_enter", 32'(field), 32'd1);
        press_set(2);
        inc_press = 1'b1;
        tick();
        inc_press = 1'b0;
        chk("post_rst_month", 32'(strobes), 32'(5'b00100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have port clk_100hz, input, 1 bit: 100 Hz system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port set_press, input, 1 bit: debounced one-cycle pulse; enters or advances set mode.
REQ-004 The block SHALL have port inc_press, input, 1 bit: debounced one-cycle pulse; increments the selected field.
REQ-005 The block SHALL have port inc_hold, input, 1 bit: debounced level of the increment button; drives auto-repeat.
REQ-006 The block SHALL have port field, output, 3 bits: current state/field code (000 RUN, 001 HOUR, 010 MIN, 011 MONTH, 100 DAY, 101 YEAR).
REQ-007 The block SHALL have port run_en, output, 1 bit: 1 lets the timekeeping counters advance; 0 freezes them.
REQ-008 The block SHALL have ports inc_hour, inc_min, inc_month, inc_day and inc_year, each an output of 1 bit: one-cycle increment strobes to the datapath counters.
REQ-009 The block SHALL have port sec_clr, output, 1 bit: one-cycle strobe that zeroes the seconds counter.
REQ-010 The block SHALL have port blink, output, 1 bit: 1 blanks the selected field on the display.
REQ-011 All outputs SHALL be driven directly from flip-flops.

Function
REQ-012 The state machine SHALL advance on a sampled set_press as follows: RUN->HOUR->MIN->MONTH->DAY->YEAR->RUN.
REQ-013 When set_press is low and no timeout occurs, the state SHALL hold.
REQ-014 Encodings 110 and 111 SHALL go to RUN on the next edge, with all strobes low.
REQ-015 run_en SHALL be 1 only in RUN, and SHALL update on the same edge as field.
REQ-016 sec_clr SHALL pulse for one cycle on the edge that leaves MIN by set_press; it SHALL NOT pulse on a timeout exit.
REQ-017 An inc_press sampled high in a SET state SHALL assert exactly the strobe for that field for one cycle, starting after that same edge (latency 1).
REQ-018 inc_press in RUN SHALL be ignored.
REQ-019 When set_press and inc_press are sampled high together, set_press SHALL win: the state advances and no strobe is issued.
REQ-020 Auto-repeat, hold counter, 7 bits:
- the counter SHALL be cleared when inc_hold=0 or when field changes;
- it SHALL count while inc_hold=1 in a SET state, saturating at 127;
- after 50 consecutive hold cycles, one strobe SHALL be issued;
- a further strobe SHALL then be issued every 10 cycles (hold counts 50, 60, 70, ... per the repeat sub-counter) for as long as inc_hold stays 1.
REQ-021 The strobe from the initial inc_press SHALL count as the first strobe; auto-repeat starts only after 50 cycles.
REQ-022 At most one strobe SHALL be active in any cycle.
REQ-023 Timeout, 10-bit inactivity counter:
- it SHALL be cleared on set_press, inc_press, inc_hold=1, or any state change;
- it SHALL increment otherwise in SET states;
- on reaching 999 (10 s idle), the next edge SHALL go to RUN.
REQ-024 The timeout counter SHALL be held at 0 in RUN.
REQ-025 blink SHALL be 0 in RUN.
REQ-026 In SET states, blink SHALL toggle every 50 cycles (1 Hz blink).
REQ-027 blink SHALL restart at 0 on every state change and on every strobe, so the field is visible while being edited.
REQ-028 The block SHALL hold no field values; wrap-around of hour, day and so on SHALL remain the datapath's responsibility.

Reset
REQ-029 While rst=0, the block SHALL drive field=000 and run_en=1, with all strobes, sec_clr and blink at 0.
REQ-030 While rst=0, all internal counters SHALL be 0.
REQ-031 Asserting rst mid-edit SHALL abort set mode immediately, with no strobe issued.
REQ-032 The first edge after rst releases SHALL evaluate the inputs normally.

Verification
REQ-033 The bench SHALL check the full cycle: 6 set_press pulses spaced 5 cycles -> field 001,010,011,100,101,000; run_en 0 for fields 001-101; sec_clr high for exactly 1 cycle after the 2nd->3rd press.
REQ-034 The bench SHALL check single increments: in MIN, 3 inc_press pulses -> exactly 3 one-cycle inc_min pulses, each 1 cycle after its press; other strobes stay 0.
REQ-035 The bench SHALL check auto-repeat: in HOUR, inc_press plus inc_hold high for 100 cycles -> inc_hour at cycle 1, then at hold counts 50, 60, 70, 80, 90, 100 (7 total).
REQ-036 The bench SHALL check timeout: enter DAY, then idle for 1000 cycles -> field=000 at cycle 1000, run_en=1, sec_clr stays 0.
REQ-037 The bench SHALL check collision: in YEAR, set_press and inc_press in the same cycle -> field=000, inc_year never asserted.
REQ-038 The bench SHALL check reset mid-operation: rst low during an auto-repeat in MONTH -> outputs at reset values immediately; after release, field=000 and inc_month=0 until a new press in set mode.
